// File: rtl/stream_demux_1xn_if.sv
// Stream bundle between one producer and N consumer channels of stream_demux_1xn.
// The slave modport is the demux; the master modport is the producer/consumer side.
interface stream_demux_1xn_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [WIDTH-1:0]   in_data;
  logic [SELW-1:0]    in_sel;
  logic               in_bcast;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_sel, in_bcast, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_bcast, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux: holds one beat, delivers it to one or all
// channels with independent per-channel handshakes, and counts dropped beats.
module stream_demux_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  stream_demux_1xn_if.slave bus,
  output logic            drop_pulse,
  output logic [CNTW-1:0] drop_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     pending_reg, pending_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             drop_pulse_reg, drop_pulse_next;
  logic [CNTW-1:0]  drop_cnt_reg, drop_cnt_next;
  logic [N-1:0]     sel_onehot;
  logic             sel_in_range;

  // Selects >= N only exist when N is not a power of two.
  assign sel_in_range = (int'(bus.in_sel) < N);

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign sel_onehot[gi] = (bus.in_sel == SELW'(gi));
    assign bus.out_data[gi*WIDTH +: WIDTH] = data_reg;
  end

  assign bus.in_ready  = (state_reg == EMPTY) && !rst;
  assign bus.out_valid = (state_reg == FULL) ? pending_reg : '0;
  assign drop_pulse    = drop_pulse_reg;
  assign drop_cnt      = drop_cnt_reg;

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    data_next       = data_reg;
    drop_pulse_next = 1'b0;
    drop_cnt_next   = drop_cnt_reg;
    case (state_reg)
      EMPTY: begin
        if (bus.in_valid) begin
          if (bus.in_bcast) begin
            data_next    = bus.in_data;
            pending_next = '1;
            state_next   = FULL;
          end else if (sel_in_range) begin
            data_next    = bus.in_data;
            pending_next = sel_onehot;
            state_next   = FULL;
          end else begin
            drop_pulse_next = 1'b1;
            if (drop_cnt_reg != '1) begin
              drop_cnt_next = drop_cnt_reg + CNTW'(1);
            end
          end
        end
      end
      FULL: begin
        // out_valid equals pending here, so masking with ready clears exactly the handshakes.
        pending_next = pending_reg & ~bus.out_ready;
        if (pending_next == '0) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= EMPTY;
      pending_reg    <= '0;
      data_reg       <= '0;
      drop_pulse_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      data_reg       <= data_next;
      drop_pulse_reg <= drop_pulse_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: an N=4 and an N=3 instance, a transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_demux_1xn_if #(.WIDTH(8), .N(4)) if4 ();
  stream_demux_1xn_if #(.WIDTH(8), .N(3)) if3 ();

  logic       dp4, dp3;
  logic [7:0] dc4, dc3;

  stream_demux_1xn #(.WIDTH(8), .N(4), .CNTW(8)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave), .drop_pulse(dp4), .drop_cnt(dc4)
  );
  stream_demux_1xn #(.WIDTH(8), .N(3), .CNTW(8)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave), .drop_pulse(dp3), .drop_cnt(dc3)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: one held transaction per instance (index 0: N=4, 1: N=3).
  bit m_full  [2];
  int m_mask  [2];
  int m_data  [2];
  bit m_pulse [2];
  int m_cnt   [2];

  typedef struct { int ch; int data; int cyc; } dlv_t;
  dlv_t dlv[$];
  int cyc = 0;

  task automatic model_step(input int d, input bit v, input int sel, input bit bc,
                            input int data, input int rdy);
    int n = (d == 0) ? 4 : 3;
    if (rst) begin
      m_full[d] = 0; m_mask[d] = 0; m_data[d] = 0; m_pulse[d] = 0; m_cnt[d] = 0;
    end else begin
      m_pulse[d] = 0;
      if (!m_full[d]) begin
        if (v) begin
          if (bc) begin
            m_mask[d] = (1 << n) - 1; m_data[d] = data; m_full[d] = 1;
          end else if (sel < n) begin
            m_mask[d] = 1 << sel; m_data[d] = data; m_full[d] = 1;
          end else begin
            m_pulse[d] = 1;
            if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
          end
        end
      end else begin
        m_mask[d] = m_mask[d] & ~rdy;
        if (m_mask[d] == 0) m_full[d] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (if4.out_valid[i] === 1'b1 && if4.out_ready[i] === 1'b1)
        dlv.push_back('{i, int'(if4.out_data[i*8 +: 8]), cyc});
    end
    model_step(0, if4.in_valid, int'(if4.in_sel), if4.in_bcast, int'(if4.in_data), int'(if4.out_ready));
    model_step(1, if3.in_valid, int'(if3.in_sel), if3.in_bcast, int'(if3.in_data), int'(if3.out_ready));
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic ir, input logic [15:0] ov,
                         input logic [127:0] od, input logic dp, input logic [7:0] dc);
    int n = (d == 0) ? 4 : 3;
    logic [127:0] exp_od = '0;
    for (int i = 0; i < n; i++) exp_od[i*8 +: 8] = m_data[d][7:0];
    chk($sformatf("d%0d.in_ready", d), 128'(ir), 128'(!m_full[d] && !rst));
    chk($sformatf("d%0d.out_valid", d), 128'(ov), m_full[d] ? 128'(m_mask[d]) : 128'(0));
    chk($sformatf("d%0d.out_data", d), od, exp_od);
    chk($sformatf("d%0d.drop_pulse", d), 128'(dp), 128'(m_pulse[d]));
    chk($sformatf("d%0d.drop_cnt", d), 128'(dc), 128'(m_cnt[d]));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      cmp_dut(0, if4.in_ready, 16'(if4.out_valid), 128'(if4.out_data), dp4, dc4);
      cmp_dut(1, if3.in_ready, 16'(if3.out_valid), 128'(if3.out_data), dp3, dc3);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    if4.in_data = 0; if4.in_sel = 0; if4.in_bcast = 0; if4.in_valid = 0; if4.out_ready = 4'hF;
    if3.in_data = 0; if3.in_sel = 0; if3.in_bcast = 0; if3.in_valid = 0; if3.out_ready = 3'h7;
    rst = 1'b1;
    tick(); tick();
    chk("reset.in_ready", 128'(if4.in_ready), 0);
    chk("reset.out_valid", 128'(if4.out_valid), 0);
    chk("reset.out_data", 128'(if4.out_data), 0);
    chk("reset.drop_cnt", 128'(dc4), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    #1 chk("reset.in_ready_release", 128'(if4.in_ready), 1);

    // Basic route
    if4.in_data = 8'hA5; if4.in_sel = 2; if4.in_valid = 1;
    tick();
    if4.in_valid = 0;
    chk("basic.out_valid", 128'(if4.out_valid), 128'(4'b0100));
    chk("basic.slice2", 128'(if4.out_data[23:16]), 128'(8'hA5));
    chk("basic.in_ready_busy", 128'(if4.in_ready), 0);
    tick();
    chk("basic.out_valid_done", 128'(if4.out_valid), 0);
    chk("basic.in_ready_back", 128'(if4.in_ready), 1);

    // Broadcast with staggered ready 3,0,2,1
    if4.out_ready = 4'b0000;
    if4.in_data = 8'h3C; if4.in_bcast = 1; if4.in_valid = 1;
    tick();
    if4.in_valid = 0; if4.in_bcast = 0;
    chk("bcast.step0", 128'(if4.out_valid), 128'(4'b1111));
    if4.out_ready = 4'b1000; tick();
    chk("bcast.step1", 128'(if4.out_valid), 128'(4'b0111));
    if4.out_ready = 4'b0001; tick();
    chk("bcast.step2", 128'(if4.out_valid), 128'(4'b0110));
    if4.out_ready = 4'b0100; tick();
    chk("bcast.step3", 128'(if4.out_valid), 128'(4'b0010));
    chk("bcast.in_ready_busy", 128'(if4.in_ready), 0);
    if4.out_ready = 4'b0010; tick();
    chk("bcast.step4", 128'(if4.out_valid), 0);
    chk("bcast.in_ready_back", 128'(if4.in_ready), 1);

    // Back-pressure on channel 1
    base = dlv.size();
    if4.out_ready = 4'b1101;
    if4.in_data = 8'h11; if4.in_sel = 1; if4.in_valid = 1;
    tick();
    if4.in_data = 8'h77; if4.in_sel = 3;
    for (int k = 0; k < 5; k++) begin
      chk("bp.out_valid_held", 128'(if4.out_valid), 128'(4'b0010));
      chk("bp.slice1_stable", 128'(if4.out_data[15:8]), 128'(8'h11));
      chk("bp.in_ready_low", 128'(if4.in_ready), 0);
      tick();
    end
    if4.out_ready = 4'hF;
    tick();
    chk("bp.released", 128'(if4.out_valid), 0);
    tick();
    if4.in_valid = 0;
    chk("bp.second_beat", 128'(if4.out_valid), 128'(4'b1000));
    chk("bp.slice3", 128'(if4.out_data[31:24]), 128'(8'h77));
    tick();
    chk("bp.dlv_count", 128'(dlv.size() - base), 2);
    if (dlv.size() - base == 2) begin
      chk("bp.dlv0", 128'({dlv[base].ch, dlv[base].data}), 128'({32'd1, 32'h11}));
      chk("bp.dlv1", 128'({dlv[base+1].ch, dlv[base+1].data}), 128'({32'd3, 32'h77}));
    end

    // Out-of-range select on the N=3 instance
    if3.in_data = 8'h99; if3.in_sel = 3; if3.in_valid = 1;
    tick();
    if3.in_valid = 0;
    chk("oor.pulse", 128'(dp3), 1);
    chk("oor.cnt1", 128'(dc3), 1);
    chk("oor.no_valid", 128'(if3.out_valid), 0);
    chk("oor.data_kept", 128'(if3.out_data), 0);
    tick();
    chk("oor.pulse_one_cycle", 128'(dp3), 0);
    if3.in_valid = 1;
    repeat (300) tick();
    if3.in_valid = 0;
    tick();
    chk("oor.saturated", 128'(dc3), 255);
    if3.in_data = 8'h5A; if3.in_sel = 2; if3.in_valid = 1;
    tick();
    if3.in_valid = 0;
    chk("n3.route_valid", 128'(if3.out_valid), 128'(3'b100));
    chk("n3.route_slice2", 128'(if3.out_data[23:16]), 128'(8'h5A));
    tick();

    // Reset mid-operation
    if4.out_ready = 4'b0001;
    if4.in_data = 8'hFF; if4.in_bcast = 1; if4.in_valid = 1;
    tick();
    if4.in_valid = 0; if4.in_bcast = 0;
    tick();
    chk("rstmid.partial", 128'(if4.out_valid), 128'(4'b1110));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = dlv.size();
    chk("rstmid.out_valid", 128'(if4.out_valid), 0);
    chk("rstmid.out_data", 128'(if4.out_data), 0);
    chk("rstmid.drop_cnt_n3", 128'(dc3), 0);
    if4.out_ready = 4'hF;
    if4.in_data = 8'h12; if4.in_sel = 0; if4.in_valid = 1;
    tick();
    if4.in_valid = 0;
    chk("rstmid.next_valid", 128'(if4.out_valid), 128'(4'b0001));
    chk("rstmid.next_slice0", 128'(if4.out_data[7:0]), 128'(8'h12));
    tick(); tick(); tick();
    chk("rstmid.dlv_count", 128'(dlv.size() - base), 1);
    if (dlv.size() - base == 1)
      chk("rstmid.dlv0", 128'({dlv[base].ch, dlv[base].data}), 128'({32'd0, 32'h12}));

    // Back-to-back streaming
    base = dlv.size();
    if4.in_valid = 1;
    for (int j = 0; j < 4; j++) begin
      if4.in_sel = 2'(j); if4.in_data = 8'(j + 1);
      tick(); tick();
    end
    if4.in_valid = 0;
    tick();
    chk("stream.count", 128'(dlv.size() - base), 4);
    if (dlv.size() - base == 4) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("stream.beat%0d", j), 128'({dlv[base+j].ch, dlv[base+j].data}),
            128'({j, j + 1}));
        if (j > 0)
          chk($sformatf("stream.gap%0d", j), 128'(dlv[base+j].cyc - dlv[base+j-1].cyc), 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
